// File: rtl/e203_subsys_rstseq.sv
// Reset sequencer: holds all domain resets, then releases them in stages.
// Ports: clk, rst_a, test_mode, sw_rst_req/ack, wdg_rst_req, dom_rst_n, busy, rst_done, rst_cause.
module e203_subsys_rstseq #(
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4,
  parameter int NUM_DOM     = 3
) (
  input  logic               clk,
  input  logic               rst_a,
  input  logic               test_mode,
  input  logic               sw_rst_req,
  input  logic               wdg_rst_req,
  output logic               sw_rst_ack,
  output logic [NUM_DOM-1:0] dom_rst_n,
  output logic               busy,
  output logic               rst_done,
  output logic [1:0]         rst_cause
);

  localparam int IW = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LAST  = 8'(STAGE_GAP - 1);
  localparam logic [IW-1:0] DOM_LAST = IW'(NUM_DOM - 1);

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    RELEASE,
    DONE
  } state_t;

  state_t             st_q, st_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [NUM_DOM-1:0] dom_q, dom_d;
  logic               sw_seen_q;
  logic               sw_seq_q;
  logic               ack_q;
  logic               done_q;
  logic               busy_q;
  logic [1:0]         cause_q;
  logic               rst_int;
  logic               sw_acc;
  logic               wdg_acc;
  logic               any_acc;
  logic [7:0]         cnt_inc;

  // Scan mode must keep the sequencer frozen even while rst_a toggles.
  assign rst_int = rst_a & ~test_mode;

  // sw_seen_q makes one level-held request count exactly once.
  assign sw_acc  = sw_rst_req & ~ack_q & ~sw_seen_q & ~test_mode;
  assign wdg_acc = wdg_rst_req & ~test_mode;
  assign any_acc = sw_acc | wdg_acc;
  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    dom_d = dom_q;
    if (!test_mode) begin
      unique case (st_q)
        IDLE: begin
          if (any_acc) begin
            st_d  = ASSERT;
            cnt_d = '0;
            dom_d = '0;
          end
        end
        ASSERT: begin
          if (any_acc) begin
            cnt_d = '0;
          end else if (cnt_q == HOLD_LAST) begin
            dom_d[0] = 1'b1;
            cnt_d    = '0;
            idx_d    = IW'(1);
            st_d     = (NUM_DOM == 1) ? DONE : RELEASE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        RELEASE: begin
          if (any_acc) begin
            st_d  = ASSERT;
            cnt_d = '0;
            dom_d = '0;
          end else if (cnt_q == GAP_LAST) begin
            dom_d[idx_q] = 1'b1;
            cnt_d        = '0;
            if (idx_q == DOM_LAST) begin
              st_d = DONE;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        DONE: begin
          if (any_acc) begin
            st_d  = ASSERT;
            cnt_d = '0;
            dom_d = '0;
          end else begin
            st_d = IDLE;
          end
        end
        default: st_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      st_q      <= ASSERT;
      cnt_q     <= '0;
      idx_q     <= '0;
      dom_q     <= '0;
      sw_seen_q <= 1'b0;
      sw_seq_q  <= 1'b0;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b1;
      cause_q   <= '0;
    end else if (!test_mode) begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      dom_q  <= dom_d;
      done_q <= (st_d == DONE);
      busy_q <= (st_d != IDLE);
      if (sw_acc) begin
        sw_seen_q <= 1'b1;
      end else if (!sw_rst_req) begin
        sw_seen_q <= 1'b0;
      end
      // A fresh sequence from IDLE starts a new cause record.
      if (any_acc && st_q == IDLE) begin
        sw_seq_q <= sw_acc;
        cause_q  <= {wdg_acc, sw_acc};
      end else begin
        sw_seq_q <= sw_seq_q | sw_acc;
        cause_q  <= cause_q | {wdg_acc, sw_acc};
      end
      if (st_d == DONE && st_q != DONE && sw_seq_q) begin
        ack_q <= 1'b1;
      end else if (!sw_rst_req) begin
        ack_q <= 1'b0;
      end
    end
  end

  assign dom_rst_n  = test_mode ? {NUM_DOM{~rst_a}} : dom_q;
  assign sw_rst_ack = ack_q;
  assign busy       = busy_q;
  assign rst_done   = done_q;
  assign rst_cause  = cause_q;

endmodule

// File: tb/tb_e203_subsys_rstseq.sv
// Bench for e203_subsys_rstseq at default parameters.
// Expected outputs are queued per scenario and compared as cycles elapse.
module tb_e203_subsys_rstseq;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1;
  logic       test_mode = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic       wdg_rst_req = 1'b0;
  logic       sw_rst_ack;
  logic [2:0] dom_rst_n;
  logic       busy;
  logic       rst_done;
  logic [1:0] rst_cause;

  typedef struct {
    int         at;
    logic [2:0] dom;
    logic       done;
    logic       busy;
    logic       ack;
    logic [1:0] cause;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   vecs = 0;
  int   errs = 0;
  int   edge_n = 0;

  e203_subsys_rstseq #(
    .HOLD_CYCLES(16),
    .STAGE_GAP(4),
    .NUM_DOM(3)
  ) dut (
    .clk(clk),
    .rst_a(rst_a),
    .test_mode(test_mode),
    .sw_rst_req(sw_rst_req),
    .wdg_rst_req(wdg_rst_req),
    .sw_rst_ack(sw_rst_ack),
    .dom_rst_n(dom_rst_n),
    .busy(busy),
    .rst_done(rst_done),
    .rst_cause(rst_cause)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic void push(int at, logic [2:0] d, logic dn,
                               logic b, logic a, logic [1:0] c);
    exp_t x;
    x.at = at; x.dom = d; x.done = dn;
    x.busy = b; x.ack = a; x.cause = c;
    sb.push_back(x);
  endfunction

  task automatic test_reset();
    int r;
    @(negedge clk);
    @(negedge clk);
    vecs++;
    if (dom_rst_n !== 3'b000 || busy !== 1'b1 || rst_done !== 1'b0 ||
        sw_rst_ack !== 1'b0 || rst_cause !== 2'b00) begin
      errs++;
      $display("FAIL reset_state: got dom=%b busy=%b done=%b ack=%b cause=%b want 000 1 0 0 00",
               dom_rst_n, busy, rst_done, sw_rst_ack, rst_cause);
    end
    r = edge_n;
    rst_a = 1'b0;
    push(r+1,  3'b000, 0, 1, 0, 2'b00);
    push(r+15, 3'b000, 0, 1, 0, 2'b00);
    push(r+16, 3'b001, 0, 1, 0, 2'b00);
    push(r+19, 3'b001, 0, 1, 0, 2'b00);
    push(r+20, 3'b011, 0, 1, 0, 2'b00);
    push(r+23, 3'b011, 0, 1, 0, 2'b00);
    push(r+24, 3'b111, 1, 1, 0, 2'b00);
    push(r+25, 3'b111, 0, 0, 0, 2'b00);
    while (sb.size() > 0) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= edge_n) begin
        e = sb.pop_front();
        vecs++;
        if (dom_rst_n !== e.dom || rst_done !== e.done || busy !== e.busy ||
            sw_rst_ack !== e.ack || rst_cause !== e.cause) begin
          errs++;
          $display("FAIL power_on E+%0d: got dom=%b done=%b busy=%b ack=%b cause=%b want %b %b %b %b %b",
                   edge_n-r, dom_rst_n, rst_done, busy, sw_rst_ack, rst_cause,
                   e.dom, e.done, e.busy, e.ack, e.cause);
        end
      end
    end
  endtask

  task automatic test_sw_req();
    int s;
    @(negedge clk);
    s = edge_n + 1;
    sw_rst_req = 1'b1;
    push(s,    3'b000, 0, 1, 0, 2'b01);
    push(s+15, 3'b000, 0, 1, 0, 2'b01);
    push(s+16, 3'b001, 0, 1, 0, 2'b01);
    push(s+20, 3'b011, 0, 1, 0, 2'b01);
    push(s+24, 3'b111, 1, 1, 1, 2'b01);
    push(s+25, 3'b111, 0, 0, 1, 2'b01);
    push(s+30, 3'b111, 0, 0, 1, 2'b01);
    push(s+31, 3'b111, 0, 0, 0, 2'b01);
    while (sb.size() > 0) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= edge_n) begin
        e = sb.pop_front();
        vecs++;
        if (dom_rst_n !== e.dom || rst_done !== e.done || busy !== e.busy ||
            sw_rst_ack !== e.ack || rst_cause !== e.cause) begin
          errs++;
          $display("FAIL sw_req E+%0d: got dom=%b done=%b busy=%b ack=%b cause=%b want %b %b %b %b %b",
                   edge_n-s, dom_rst_n, rst_done, busy, sw_rst_ack, rst_cause,
                   e.dom, e.done, e.busy, e.ack, e.cause);
        end
      end
      if (edge_n == s+30) sw_rst_req = 1'b0;
    end
  endtask

  task automatic test_hold_restart();
    int s;
    @(negedge clk);
    s = edge_n + 1;
    wdg_rst_req = 1'b1;
    push(s,    3'b000, 0, 1, 0, 2'b10);
    push(s+16, 3'b000, 0, 1, 0, 2'b10);
    push(s+20, 3'b000, 0, 1, 0, 2'b10);
    push(s+21, 3'b001, 0, 1, 0, 2'b10);
    push(s+29, 3'b111, 1, 1, 0, 2'b10);
    push(s+30, 3'b111, 0, 0, 0, 2'b10);
    while (sb.size() > 0) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= edge_n) begin
        e = sb.pop_front();
        vecs++;
        if (dom_rst_n !== e.dom || rst_done !== e.done || busy !== e.busy ||
            sw_rst_ack !== e.ack || rst_cause !== e.cause) begin
          errs++;
          $display("FAIL hold_restart E+%0d: got dom=%b done=%b busy=%b ack=%b cause=%b want %b %b %b %b %b",
                   edge_n-s, dom_rst_n, rst_done, busy, sw_rst_ack, rst_cause,
                   e.dom, e.done, e.busy, e.ack, e.cause);
        end
      end
      if (edge_n == s)   wdg_rst_req = 1'b0;
      if (edge_n == s+4) wdg_rst_req = 1'b1;
      if (edge_n == s+5) wdg_rst_req = 1'b0;
    end
  endtask

  task automatic test_wdg_double();
    int s;
    int ndone;
    ndone = 0;
    @(negedge clk);
    s = edge_n + 1;
    wdg_rst_req = 1'b1;
    push(s+16, 3'b001, 0, 1, 0, 2'b10);
    push(s+17, 3'b001, 0, 1, 0, 2'b10);
    push(s+18, 3'b000, 0, 1, 0, 2'b10);
    push(s+33, 3'b000, 0, 1, 0, 2'b10);
    push(s+34, 3'b001, 0, 1, 0, 2'b10);
    push(s+41, 3'b011, 0, 1, 0, 2'b10);
    push(s+42, 3'b111, 1, 1, 0, 2'b10);
    push(s+43, 3'b111, 0, 0, 0, 2'b10);
    while (sb.size() > 0) begin
      @(negedge clk);
      if (rst_done === 1'b1) ndone++;
      while (sb.size() > 0 && sb[0].at <= edge_n) begin
        e = sb.pop_front();
        vecs++;
        if (dom_rst_n !== e.dom || rst_done !== e.done || busy !== e.busy ||
            sw_rst_ack !== e.ack || rst_cause !== e.cause) begin
          errs++;
          $display("FAIL wdg_double E+%0d: got dom=%b done=%b busy=%b ack=%b cause=%b want %b %b %b %b %b",
                   edge_n-s, dom_rst_n, rst_done, busy, sw_rst_ack, rst_cause,
                   e.dom, e.done, e.busy, e.ack, e.cause);
        end
      end
      if (edge_n == s)    wdg_rst_req = 1'b0;
      if (edge_n == s+17) wdg_rst_req = 1'b1;
      if (edge_n == s+18) wdg_rst_req = 1'b0;
    end
    vecs++;
    if (ndone !== 1) begin
      errs++;
      $display("FAIL wdg_double_done_count: got %0d pulses want 1", ndone);
    end
  endtask

  task automatic test_both();
    int s;
    @(negedge clk);
    s = edge_n + 1;
    sw_rst_req  = 1'b1;
    wdg_rst_req = 1'b1;
    push(s,    3'b000, 0, 1, 0, 2'b11);
    push(s+16, 3'b001, 0, 1, 0, 2'b11);
    push(s+24, 3'b111, 1, 1, 1, 2'b11);
    push(s+25, 3'b111, 0, 0, 1, 2'b11);
    push(s+26, 3'b111, 0, 0, 0, 2'b11);
    while (sb.size() > 0) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= edge_n) begin
        e = sb.pop_front();
        vecs++;
        if (dom_rst_n !== e.dom || rst_done !== e.done || busy !== e.busy ||
            sw_rst_ack !== e.ack || rst_cause !== e.cause) begin
          errs++;
          $display("FAIL both_req E+%0d: got dom=%b done=%b busy=%b ack=%b cause=%b want %b %b %b %b %b",
                   edge_n-s, dom_rst_n, rst_done, busy, sw_rst_ack, rst_cause,
                   e.dom, e.done, e.busy, e.ack, e.cause);
        end
      end
      if (edge_n == s)    wdg_rst_req = 1'b0;
      if (edge_n == s+25) sw_rst_req = 1'b0;
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    test_mode   = 1'b1;
    rst_a       = 1'b1;
    sw_rst_req  = 1'b1;
    wdg_rst_req = 1'b1;
    #1;
    vecs++;
    if (dom_rst_n !== 3'b000 || busy !== 1'b0 || rst_cause !== 2'b11) begin
      errs++;
      $display("FAIL bypass_rst_hi: got dom=%b busy=%b cause=%b want 000 0 11",
               dom_rst_n, busy, rst_cause);
    end
    repeat (3) @(negedge clk);
    vecs++;
    if (dom_rst_n !== 3'b000 || busy !== 1'b0 || rst_cause !== 2'b11 ||
        rst_done !== 1'b0 || sw_rst_ack !== 1'b0) begin
      errs++;
      $display("FAIL bypass_hold: got dom=%b busy=%b cause=%b done=%b ack=%b want 000 0 11 0 0",
               dom_rst_n, busy, rst_cause, rst_done, sw_rst_ack);
    end
    rst_a = 1'b0;
    #1;
    vecs++;
    if (dom_rst_n !== 3'b111) begin
      errs++;
      $display("FAIL bypass_rst_lo: got dom=%b want 111", dom_rst_n);
    end
    repeat (2) @(negedge clk);
    vecs++;
    if (busy !== 1'b0 || rst_cause !== 2'b11 || dom_rst_n !== 3'b111) begin
      errs++;
      $display("FAIL bypass_req_ignored: got busy=%b cause=%b dom=%b want 0 11 111",
               busy, rst_cause, dom_rst_n);
    end
    sw_rst_req  = 1'b0;
    wdg_rst_req = 1'b0;
    @(negedge clk);
    test_mode = 1'b0;
    @(negedge clk);
    vecs++;
    if (busy !== 1'b0 || rst_cause !== 2'b11 || dom_rst_n !== 3'b111 ||
        rst_done !== 1'b0) begin
      errs++;
      $display("FAIL bypass_exit: got busy=%b cause=%b dom=%b done=%b want 0 11 111 0",
               busy, rst_cause, dom_rst_n, rst_done);
    end
  endtask

  task automatic test_rst_mid();
    int s;
    int r;
    @(negedge clk);
    s = edge_n + 1;
    sw_rst_req = 1'b1;
    push(s,   3'b000, 0, 1, 0, 2'b01);
    push(s+9, 3'b000, 0, 1, 0, 2'b01);
    while (sb.size() > 0) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= edge_n) begin
        e = sb.pop_front();
        vecs++;
        if (dom_rst_n !== e.dom || rst_done !== e.done || busy !== e.busy ||
            sw_rst_ack !== e.ack || rst_cause !== e.cause) begin
          errs++;
          $display("FAIL rst_mid_pre E+%0d: got dom=%b done=%b busy=%b ack=%b cause=%b want %b %b %b %b %b",
                   edge_n-s, dom_rst_n, rst_done, busy, sw_rst_ack, rst_cause,
                   e.dom, e.done, e.busy, e.ack, e.cause);
        end
      end
    end
    @(posedge clk);
    #1;
    rst_a = 1'b1;
    #1;
    vecs++;
    if (dom_rst_n !== 3'b000 || busy !== 1'b1 || rst_done !== 1'b0 ||
        sw_rst_ack !== 1'b0 || rst_cause !== 2'b00) begin
      errs++;
      $display("FAIL rst_mid_async: got dom=%b busy=%b done=%b ack=%b cause=%b want 000 1 0 0 00",
               dom_rst_n, busy, rst_done, sw_rst_ack, rst_cause);
    end
    sw_rst_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    r = edge_n;
    rst_a = 1'b0;
    push(r+15, 3'b000, 0, 1, 0, 2'b00);
    push(r+16, 3'b001, 0, 1, 0, 2'b00);
    push(r+20, 3'b011, 0, 1, 0, 2'b00);
    push(r+24, 3'b111, 1, 1, 0, 2'b00);
    push(r+25, 3'b111, 0, 0, 0, 2'b00);
    while (sb.size() > 0) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= edge_n) begin
        e = sb.pop_front();
        vecs++;
        if (dom_rst_n !== e.dom || rst_done !== e.done || busy !== e.busy ||
            sw_rst_ack !== e.ack || rst_cause !== e.cause) begin
          errs++;
          $display("FAIL rst_mid_post E+%0d: got dom=%b done=%b busy=%b ack=%b cause=%b want %b %b %b %b %b",
                   edge_n-r, dom_rst_n, rst_done, busy, sw_rst_ack, rst_cause,
                   e.dom, e.done, e.busy, e.ack, e.cause);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sw_req();
    test_hold_restart();
    test_wdg_double();
    test_both();
    test_bypass();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1);
  end

endmodule
